// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch stage feeding a byte-addressed instruction ROM.
// Owns the program counter, captures the ROM word into an IF/ID register and
// hands it to decode over a valid/ready handshake. Handles redirects,
// back-pressure, end-of-ROM halt and misaligned-redirect faults.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pc_o              fetch address to ROM (registered)
//   instr_i           ROM word, combinational from pc_o
//   redirect_valid_i  taken branch/jump this cycle
//   redirect_pc_i     redirect target
//   id_ready_i        decode accepts IF/ID contents this cycle
//   if_valid_o        IF/ID holds a valid instruction
//   if_instr_o        captured instruction
//   if_pc_o           PC of captured instruction
//   if_pc_plus4_o     if_pc_o + 4 (link/return address)
//   halted_o          high while in HALT
//   fault_o           sticky misaligned-redirect fault
module pc_fetch_unit #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned ROM_BYTES = 28
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  input  logic [31:0]              instr_i,
  input  logic                     redirect_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  input  logic                     id_ready_i,
  output logic                     if_valid_o,
  output logic [31:0]              if_instr_o,
  output logic [ADDRESS_WIDTH-1:0] if_pc_o,
  output logic [ADDRESS_WIDTH-1:0] if_pc_plus4_o,
  output logic                     halted_o,
  output logic                     fault_o
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_PC = ADDRESS_WIDTH'(ROM_BYTES - 4);
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t state;

  logic in_range_c;
  logic cap_c;
  logic xfer_c;
  logic misaligned_c;

  // Capture / handshake qualifiers
  always_comb begin
    in_range_c   = (pc_o <= LAST_PC);
    xfer_c       = if_valid_o && id_ready_i;
    misaligned_c = (redirect_pc_i[1:0] != 2'b00);
    cap_c        = (state == RUN) && !redirect_valid_i &&
                   (!if_valid_o || id_ready_i) && in_range_c;
  end

  // Fetch state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc_o          <= RESET_PC;
      if_valid_o    <= 1'b0;
      if_instr_o    <= '0;
      if_pc_o       <= '0;
      if_pc_plus4_o <= '0;
      halted_o      <= 1'b0;
      fault_o       <= 1'b0;
    end else if (state != FAULT) begin
      if (redirect_valid_i) begin
        // Redirect flushes IF/ID regardless of decode readiness
        if_valid_o <= 1'b0;
        halted_o   <= 1'b0;
        if (misaligned_c) begin
          state   <= FAULT;
          fault_o <= 1'b1;
        end else begin
          pc_o  <= redirect_pc_i;
          state <= RUN;
        end
      end else begin
        case (state)
          BOOT: state <= RUN;
          RUN: begin
            if (cap_c) begin
              if_instr_o    <= instr_i;
              if_pc_o       <= pc_o;
              if_pc_plus4_o <= pc_o + PC_STEP;
              if_valid_o    <= 1'b1;
              pc_o          <= pc_o + PC_STEP;
            end else begin
              if (xfer_c) if_valid_o <= 1'b0;
              // Past the last word: stop fetching, let the held entry drain
              if (!in_range_c) begin
                state    <= HALT;
                halted_o <= 1'b1;
              end
            end
          end
          HALT: begin
            if (xfer_c) if_valid_o <= 1'b0;
          end
          default: state <= FAULT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit with a 7-word ROM model.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus4_o;
  logic        halted_o;
  logic        fault_o;

  int tests;
  int fails;

  pc_fetch_unit #(
    .ADDRESS_WIDTH(32),
    .RESET_PC(32'h0),
    .ROM_BYTES(28)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc_o(pc_o),
    .instr_i(instr_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i),
    .id_ready_i(id_ready_i),
    .if_valid_o(if_valid_o),
    .if_instr_o(if_instr_o),
    .if_pc_o(if_pc_o),
    .if_pc_plus4_o(if_pc_plus4_o),
    .halted_o(halted_o),
    .fault_o(fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: word at byte address 4*k is 32'hC0DE_0000 + k
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a < 32'd28) return 32'hC0DE_0000 + 32'(a >> 2);
    return 32'hDEAD_BEEF;
  endfunction

  assign instr_i = rom_word(pc_o);

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'h0;
    id_ready_i       = 1'b1;
    rst_n            = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'h0;
    id_ready_i       = 1'b1;
    rst_n            = 1'b0;
    #3;
    tests++;
    if ({pc_o, if_valid_o, if_instr_o, if_pc_o, if_pc_plus4_o, halted_o, fault_o} !==
        {32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset: pc=%h v=%b instr=%h ifpc=%h p4=%h h=%b f=%b, required all zero",
               pc_o, if_valid_o, if_instr_o, if_pc_o, if_pc_plus4_o, halted_o, fault_o);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    do_reset();
    step();
    tests++;
    if ({if_valid_o, pc_o, halted_o} !== {1'b0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL boot_bubble: v=%b pc=%h h=%b, required v=0 pc=0 h=0", if_valid_o, pc_o, halted_o);
    end
    for (int k = 0; k < 7; k++) begin
      step();
      tests++;
      if ({if_valid_o, if_pc_o, if_instr_o, if_pc_plus4_o, pc_o} !==
          {1'b1, 32'(4 * k), 32'hC0DE_0000 + 32'(k), 32'(4 * k + 4), 32'(4 * k + 4)}) begin
        fails++;
        $display("FAIL stream_%0d: v=%b ifpc=%h instr=%h p4=%h pc=%h, required v=1 ifpc=%h instr=%h",
                 k, if_valid_o, if_pc_o, if_instr_o, if_pc_plus4_o, pc_o,
                 32'(4 * k), 32'hC0DE_0000 + 32'(k));
      end
    end
    step();
    tests++;
    if ({if_valid_o, halted_o, pc_o} !== {1'b0, 1'b1, 32'd28}) begin
      fails++;
      $display("FAIL halt_entry: v=%b h=%b pc=%h, required v=0 h=1 pc=1c", if_valid_o, halted_o, pc_o);
    end
    step();
    step();
    tests++;
    if ({if_valid_o, halted_o, pc_o} !== {1'b0, 1'b1, 32'd28}) begin
      fails++;
      $display("FAIL halt_hold: v=%b h=%b pc=%h, required v=0 h=1 pc=1c", if_valid_o, halted_o, pc_o);
    end
  endtask

  // Runs from HALT left by test_free_run
  task automatic test_halt_redirect();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h4;
    step();
    redirect_valid_i = 1'b0;
    tests++;
    if ({halted_o, if_valid_o, pc_o} !== {1'b0, 1'b0, 32'h4}) begin
      fails++;
      $display("FAIL halt_redirect: h=%b v=%b pc=%h, required h=0 v=0 pc=4", halted_o, if_valid_o, pc_o);
    end
    step();
    tests++;
    if ({if_valid_o, if_pc_o, if_instr_o, pc_o} !== {1'b1, 32'h4, 32'hC0DE_0001, 32'h8}) begin
      fails++;
      $display("FAIL halt_resume: v=%b ifpc=%h instr=%h pc=%h, required v=1 ifpc=4 instr=c0de0001 pc=8",
               if_valid_o, if_pc_o, if_instr_o, pc_o);
    end
  endtask

  task automatic test_async_reset();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({pc_o, if_valid_o, halted_o, fault_o} !== {32'h0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: pc=%h v=%b h=%b f=%b, required all zero", pc_o, if_valid_o, halted_o, fault_o);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    step();
    step();
    id_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if ({if_valid_o, if_pc_o, if_instr_o, if_pc_plus4_o, pc_o} !==
          {1'b1, 32'h8, 32'hC0DE_0002, 32'hC, 32'hC}) begin
        fails++;
        $display("FAIL stall_%0d: v=%b ifpc=%h instr=%h p4=%h pc=%h, required v=1 ifpc=8 instr=c0de0002 p4=c pc=c",
                 c, if_valid_o, if_pc_o, if_instr_o, if_pc_plus4_o, pc_o);
      end
    end
    id_ready_i = 1'b1;
    step();
    tests++;
    if ({if_valid_o, if_pc_o, if_instr_o, pc_o} !== {1'b1, 32'hC, 32'hC0DE_0003, 32'h10}) begin
      fails++;
      $display("FAIL stall_release: v=%b ifpc=%h instr=%h pc=%h, required v=1 ifpc=c instr=c0de0003 pc=10",
               if_valid_o, if_pc_o, if_instr_o, pc_o);
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    step();
    step();
    step();
    id_ready_i       = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h10;
    step();
    redirect_valid_i = 1'b0;
    tests++;
    if ({if_valid_o, pc_o} !== {1'b0, 32'h10}) begin
      fails++;
      $display("FAIL redirect_flush: v=%b pc=%h, required v=0 pc=10", if_valid_o, pc_o);
    end
    step();
    tests++;
    if ({if_valid_o, if_pc_o, if_instr_o, if_pc_plus4_o, pc_o} !==
        {1'b1, 32'h10, 32'hC0DE_0004, 32'h14, 32'h14}) begin
      fails++;
      $display("FAIL redirect_target: v=%b ifpc=%h instr=%h p4=%h pc=%h, required v=1 ifpc=10 instr=c0de0004 p4=14 pc=14",
               if_valid_o, if_pc_o, if_instr_o, if_pc_plus4_o, pc_o);
    end
    id_ready_i = 1'b1;
  endtask

  task automatic test_fault();
    do_reset();
    step();
    step();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h6;
    step();
    tests++;
    if ({fault_o, if_valid_o, pc_o} !== {1'b1, 1'b0, 32'h4}) begin
      fails++;
      $display("FAIL fault_entry: f=%b v=%b pc=%h, required f=1 v=0 pc=4", fault_o, if_valid_o, pc_o);
    end
    redirect_pc_i = 32'h0;
    for (int c = 0; c < 10; c++) begin
      step();
      tests++;
      if ({fault_o, if_valid_o, pc_o} !== {1'b1, 1'b0, 32'h4}) begin
        fails++;
        $display("FAIL fault_hold_%0d: f=%b v=%b pc=%h, required f=1 v=0 pc=4", c, fault_o, if_valid_o, pc_o);
      end
    end
    redirect_valid_i = 1'b0;
    do_reset();
    step();
    step();
    tests++;
    if ({fault_o, if_valid_o, if_pc_o} !== {1'b0, 1'b1, 32'h0}) begin
      fails++;
      $display("FAIL fault_recover: f=%b v=%b ifpc=%h, required f=0 v=1 ifpc=0", fault_o, if_valid_o, if_pc_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i = 32'h0;
    id_ready_i = 1'b1;
    #2;
    test_reset();
    test_free_run();
    test_halt_redirect();
    test_async_reset();
    test_stall();
    test_redirect_flush();
    test_fault();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Fetch stage directly upstream of the byte-addressed instruction ROM. Owns the program counter and drives it to the ROM's PC input. Captures the combinational 32-bit instruction word returned by the ROM into an IF/ID holding register, and offers it to decode over a valid/ready handshake. Also handles branch/jump redirects, decode back-pressure, end-of-ROM halt and misaligned-target faults.

Parameters:
ADDRESS_WIDTH, 32, width of PC and all address ports
RESET_PC, 0, PC value loaded on reset
ROM_BYTES, 28, ROM size in bytes; last legal fetch address is ROM_BYTES-4

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
pc_o  output  ADDRESS_WIDTH  fetch address to ROM PC input (registered)
instr_i  input  32  instruction word from ROM, combinational from pc_o
redirect_valid_i  input  1  taken branch/jump this cycle
redirect_pc_i  input  ADDRESS_WIDTH  redirect target
id_ready_i  input  1  decode accepts IF/ID contents this cycle
if_valid_o  output  1  IF/ID register holds a valid instruction
if_instr_o  output  32  captured instruction
if_pc_o  output  ADDRESS_WIDTH  PC of captured instruction
if_pc_plus4_o  output  ADDRESS_WIDTH  if_pc_o + 4, used for link and return addresses
halted_o  output  1  high in HALT state
fault_o  output  1  sticky misaligned-redirect fault

Behaviour:
- Reset (async assert, sync release by clk edge): pc_o=RESET_PC, if_valid_o=0, if_instr_o=0, if_pc_o=0, if_pc_plus4_o=0, halted_o=0, fault_o=0, state=BOOT.
- States are BOOT, RUN, HALT and FAULT.
- BOOT: one bubble cycle with no capture; it always moves to RUN next cycle. A redirect in BOOT loads pc_o and still moves to RUN.
- Capture condition (cap) = state RUN, !redirect_valid_i, (!if_valid_o or id_ready_i), and pc_o <= ROM_BYTES-4.
  - On cap: if_instr_o<=instr_i, if_pc_o<=pc_o, if_pc_plus4_o<=pc_o+4, if_valid_o<=1, pc_o<=pc_o+4.
- Handshake: a transfer occurs when if_valid_o and id_ready_i.
  - Transfer with no cap: if_valid_o<=0.
  - if_valid_o and !id_ready_i: every IF/ID output and pc_o hold stable. This is a stall, with no advance and no drop.
- Redirect has the highest priority, in RUN, HALT or BOOT.
  - if_valid_o<=0 (flush), whatever the value of id_ready_i.
  - pc_o<=redirect_pc_i, and the state goes to RUN. The first capture from the target happens the cycle after the redirect.
  - If redirect_pc_i[1:0]!=0: pc_o is not updated, if_valid_o<=0, state goes to FAULT and fault_o<=1.
- End of ROM: in RUN with pc_o > ROM_BYTES-4 and no redirect, the state goes to HALT and halted_o<=1. Any outstanding valid entry stays until it is transferred; no new capture occurs. HALT leaves only on a redirect (halted_o<=0) or on reset.
- FAULT: absorbing; only rst_n leaves it. if_valid_o stays 0, pc_o is frozen, redirects are ignored.
- Arithmetic: pc_o+4 and if_pc_plus4_o wrap modulo 2^ADDRESS_WIDTH with no carry out. The range compare is unsigned.
- Simultaneous transfer and cap: back-to-back streaming, one instruction per cycle with if_valid_o held at 1.
- Reset asserted mid-stall or mid-redirect: all state returns immediately to reset values, without waiting for clk.
- Latency: an instruction at address A appears on if_instr_o one cycle after pc_o=A in RUN with cap true.

Test Plan:
- Reset then free-run with id_ready_i=1, ROM words W0..W6: BOOT bubble, then if_pc_o=0,4,...,24 on consecutive cycles with if_valid_o=1. After 24 the unit enters HALT, halted_o=1, and if_valid_o=0 once word 24 transfers.
- id_ready_i=0 for 3 cycles while if_pc_o=8: if_instr_o, if_pc_o=8, if_pc_plus4_o=12 and pc_o=12 hold for 3 cycles; after id_ready_i returns, next if_pc_o=12.
- Redirect to 0x10 while if_valid_o=1 and id_ready_i=0: next cycle if_valid_o=0 and pc_o=0x10; following cycle if_pc_o=0x10 and if_valid_o=1.
- Redirect to 0x06: fault_o=1 and pc_o unchanged; if_valid_o stays 0 for 10 cycles despite further redirects to 0x0; recovery only via rst_n.
- In HALT, redirect to 0x4: halted_o=0 and fetch resumes with if_pc_o=4. Then assert rst_n=0 asynchronously mid-cycle: pc_o=0 and if_valid_o=0 before the next clk edge.
